// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch stage
package fetch_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DROP
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;  // addi x0, x0, 0
  localparam int          PC_STEP   = 4;

endpackage

// File: rtl/next_pc_sel.sv
// rtl/next_pc_sel.sv - priority select of the next PC: redirect, sequential advance, hold
//
// Ports:
//   redirect        - take redirect_target (word aligned)
//   redirect_target - branch/jump destination
//   advance         - an instruction enters IF/ID this cycle, step by PC_STEP
//   pc              - current PC
//   next_pc         - PC for the next cycle
module next_pc_sel
  import fetch_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         redirect,
  input  logic [N-1:0] redirect_target,
  input  logic         advance,
  input  logic [N-1:0] pc,
  output logic [N-1:0] next_pc
);

  // Clearing the two low bits keeps the fetch address word aligned.
  logic [N-1:0] target_aligned;
  assign target_aligned = redirect_target & ~N'(3);

  always_comb begin
    next_pc = pc;
    if (redirect) begin
      next_pc = target_aligned;
    end else if (advance) begin
      next_pc = pc + N'(PC_STEP);
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch control with IF/ID register, stall and flush
//
// Ports:
//   clk, reset            - clock, asynchronous active-low reset
//   PC_Value / Next_PC    - current PC in, next PC out (PC register has no enable)
//   imem_req/addr/gnt     - single-outstanding fetch request handshake
//   imem_rvalid/rdata     - returned instruction word
//   redirect_valid/target - one-cycle redirect from EX, flushes IF/ID
//   id_stall              - decode cannot accept the current IF/ID contents
//   ifid_*                - IF/ID register outputs
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int           N         = 32,
  parameter logic [N-1:0] NOP_INSTR = N'(fetch_pkg::NOP_INSTR)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] PC_Value,
  output logic [N-1:0] Next_PC,
  output logic         imem_req,
  output logic [N-1:0] imem_addr,
  input  logic         imem_gnt,
  input  logic         imem_rvalid,
  input  logic [N-1:0] imem_rdata,
  input  logic         redirect_valid,
  input  logic [N-1:0] redirect_target,
  input  logic         id_stall,
  output logic         ifid_valid,
  output logic [N-1:0] ifid_instr,
  output logic [N-1:0] ifid_pc,
  output logic [N-1:0] ifid_pc_plus4
);

  fetch_state_t state;
  logic [N-1:0] hold_instr;

  logic         redirect_act;
  logic         slot_free;
  logic         load_wait;
  logic         load_hold;
  logic         advance;
  logic [N-1:0] pc_plus4;

  // Redirects arriving before the first request are meaningless and ignored.
  assign redirect_act = redirect_valid && (state != S_IDLE);
  assign slot_free    = !ifid_valid || !id_stall;
  assign load_wait    = (state == S_WAIT) && imem_rvalid && slot_free;
  assign load_hold    = (state == S_HOLD) && slot_free;
  assign advance      = (load_wait || load_hold) && !redirect_act;
  assign pc_plus4     = PC_Value + N'(PC_STEP);

  assign imem_req  = (state == S_REQ);
  assign imem_addr = PC_Value;

  next_pc_sel #(.N(N)) u_next_pc_sel (
    .redirect        (redirect_act),
    .redirect_target (redirect_target),
    .advance         (advance),
    .pc              (PC_Value),
    .next_pc         (Next_PC)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      hold_instr    <= NOP_INSTR;
      ifid_valid    <= 1'b0;
      ifid_instr    <= NOP_INSTR;
      ifid_pc       <= '0;
      ifid_pc_plus4 <= '0;
    end else if (redirect_act) begin
      // Flush: IF/ID becomes a bubble; any buffered word is simply abandoned.
      ifid_valid <= 1'b0;
      ifid_instr <= NOP_INSTR;
      case (state)
        S_REQ:   state <= imem_gnt ? S_DROP : S_REQ;
        S_WAIT:  state <= imem_rvalid ? S_REQ : S_DROP;
        S_DROP:  state <= imem_rvalid ? S_REQ : S_DROP;
        default: state <= S_REQ;
      endcase
    end else begin
      if (advance) begin
        ifid_valid    <= 1'b1;
        ifid_instr    <= load_wait ? imem_rdata : hold_instr;
        ifid_pc       <= PC_Value;
        ifid_pc_plus4 <= pc_plus4;
      end else if (slot_free) begin
        // Decode consumed the entry (or it was already empty).
        ifid_valid <= 1'b0;
      end

      case (state)
        S_IDLE: state <= S_REQ;
        S_REQ:  if (imem_gnt) state <= S_WAIT;
        S_WAIT: begin
          if (imem_rvalid) begin
            if (slot_free) begin
              state <= S_REQ;
            end else begin
              hold_instr <= imem_rdata;
              state      <= S_HOLD;
            end
          end
        end
        S_HOLD:  if (slot_free) state <= S_REQ;
        S_DROP:  if (imem_rvalid) state <= S_REQ;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] PC_Value;
  logic [N-1:0] Next_PC;
  logic         imem_req;
  logic [N-1:0] imem_addr;
  logic         imem_gnt;
  logic         imem_rvalid;
  logic [N-1:0] imem_rdata;
  logic         redirect_valid;
  logic [N-1:0] redirect_target;
  logic         id_stall;
  logic         ifid_valid;
  logic [N-1:0] ifid_instr;
  logic [N-1:0] ifid_pc;
  logic [N-1:0] ifid_pc_plus4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_stage #(.N(N)) dut (
    .clk             (clk),
    .reset           (reset),
    .PC_Value        (PC_Value),
    .Next_PC         (Next_PC),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_gnt        (imem_gnt),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .id_stall        (id_stall),
    .ifid_valid      (ifid_valid),
    .ifid_instr      (ifid_instr),
    .ifid_pc         (ifid_pc),
    .ifid_pc_plus4   (ifid_pc_plus4)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; PC_Value = 32'h00400000; imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0;
    redirect_valid = 0; redirect_target = 0; id_stall = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", ifid_valid); end
    checks++; if (ifid_instr !== 32'h00000013) begin errors++; $display("FAIL reset_instr got %h exp 00000013", ifid_instr); end
    checks++; if (ifid_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp 0", ifid_pc); end
    checks++; if (ifid_pc_plus4 !== 32'h0) begin errors++; $display("FAIL reset_pc4 got %h exp 0", ifid_pc_plus4); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", imem_req); end
    reset = 1'b1;
    redirect_valid = 1; redirect_target = 32'h00400080;
    #1;
    checks++; if (Next_PC !== 32'h00400000) begin errors++; $display("FAIL idle_redirect_ignored got %h exp 00400000", Next_PC); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL idle_req got %b exp 0", imem_req); end
    redirect_valid = 0;
    cyc();
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL first_req got %b exp 1", imem_req); end
    checks++; if (imem_addr !== 32'h00400000) begin errors++; $display("FAIL first_addr got %h exp 00400000", imem_addr); end
  endtask

  task automatic test_fetch();
    imem_gnt = 1; #1;
    checks++; if (Next_PC !== 32'h00400000) begin errors++; $display("FAIL req_next_pc got %h exp 00400000", Next_PC); end
    cyc();
    imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'h00500093; #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL wait_req got %b exp 0", imem_req); end
    checks++; if (Next_PC !== 32'h00400004) begin errors++; $display("FAIL fetch_next_pc got %h exp 00400004", Next_PC); end
    cyc();
    imem_rvalid = 0; PC_Value = 32'h00400004;
    checks++; if (ifid_valid !== 1'b1) begin errors++; $display("FAIL fetch_valid got %b exp 1", ifid_valid); end
    checks++; if (ifid_instr !== 32'h00500093) begin errors++; $display("FAIL fetch_instr got %h exp 00500093", ifid_instr); end
    checks++; if (ifid_pc !== 32'h00400000) begin errors++; $display("FAIL fetch_pc got %h exp 00400000", ifid_pc); end
    checks++; if (ifid_pc_plus4 !== 32'h00400004) begin errors++; $display("FAIL fetch_pc4 got %h exp 00400004", ifid_pc_plus4); end
  endtask

  task automatic test_stall();
    id_stall = 1; imem_gnt = 1;
    cyc();
    imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'h00100113; #1;
    checks++; if (Next_PC !== 32'h00400004) begin errors++; $display("FAIL stall_next_pc got %h exp 00400004", Next_PC); end
    cyc();
    imem_rvalid = 0;
    for (int i = 0; i < 2; i++) begin
      checks++; if (ifid_valid !== 1'b1) begin errors++; $display("FAIL hold_valid[%0d] got %b exp 1", i, ifid_valid); end
      checks++; if (ifid_instr !== 32'h00500093) begin errors++; $display("FAIL hold_instr[%0d] got %h exp 00500093", i, ifid_instr); end
      checks++; if (ifid_pc !== 32'h00400000) begin errors++; $display("FAIL hold_pc[%0d] got %h exp 00400000", i, ifid_pc); end
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL hold_req[%0d] got %b exp 0", i, imem_req); end
      checks++; if (Next_PC !== 32'h00400004) begin errors++; $display("FAIL hold_next_pc[%0d] got %h exp 00400004", i, Next_PC); end
      if (i == 0) cyc();
    end
    id_stall = 0; #1;
    checks++; if (Next_PC !== 32'h00400008) begin errors++; $display("FAIL release_next_pc got %h exp 00400008", Next_PC); end
    cyc();
    PC_Value = 32'h00400008; id_stall = 1;
    checks++; if (ifid_instr !== 32'h00100113) begin errors++; $display("FAIL release_instr got %h exp 00100113", ifid_instr); end
    checks++; if (ifid_pc !== 32'h00400004) begin errors++; $display("FAIL release_pc got %h exp 00400004", ifid_pc); end
    checks++; if (ifid_pc_plus4 !== 32'h00400008) begin errors++; $display("FAIL release_pc4 got %h exp 00400008", ifid_pc_plus4); end
  endtask

  task automatic test_redirect_wait();
    imem_gnt = 1;
    cyc();
    imem_gnt = 0; redirect_valid = 1; redirect_target = 32'h00400103; #1;
    checks++; if (Next_PC !== 32'h00400100) begin errors++; $display("FAIL redir_next_pc got %h exp 00400100", Next_PC); end
    cyc();
    redirect_valid = 0; id_stall = 0; PC_Value = 32'h00400100;
    checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b exp 0", ifid_valid); end
    checks++; if (ifid_instr !== 32'h00000013) begin errors++; $display("FAIL flush_instr got %h exp 00000013", ifid_instr); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL drop_req got %b exp 0", imem_req); end
    cyc();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL drop_wait_req got %b exp 0", imem_req); end
    imem_rvalid = 1; imem_rdata = 32'hDEADBEEF; #1;
    checks++; if (Next_PC !== 32'h00400100) begin errors++; $display("FAIL drop_next_pc got %h exp 00400100", Next_PC); end
    cyc();
    imem_rvalid = 0;
    checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL drop_discard_valid got %b exp 0", ifid_valid); end
    checks++; if (ifid_instr !== 32'h00000013) begin errors++; $display("FAIL drop_discard_instr got %h exp 00000013", ifid_instr); end
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL post_drop_req got %b exp 1", imem_req); end
    checks++; if (imem_addr !== 32'h00400100) begin errors++; $display("FAIL post_drop_addr got %h exp 00400100", imem_addr); end
  endtask

  task automatic test_redirect_rvalid();
    imem_gnt = 1;
    cyc();
    imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'h12345678;
    redirect_valid = 1; redirect_target = 32'h00400200; #1;
    checks++; if (Next_PC !== 32'h00400200) begin errors++; $display("FAIL redir_rv_next_pc got %h exp 00400200", Next_PC); end
    cyc();
    imem_rvalid = 0; redirect_valid = 0; PC_Value = 32'h00400200;
    checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL redir_rv_valid got %b exp 0", ifid_valid); end
    checks++; if (ifid_instr !== 32'h00000013) begin errors++; $display("FAIL redir_rv_instr got %h exp 00000013", ifid_instr); end
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL redir_rv_req got %b exp 1", imem_req); end
  endtask

  task automatic test_gnt_delay();
    for (int i = 0; i < 5; i++) begin
      checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL nogrant_req[%0d] got %b exp 1", i, imem_req); end
      checks++; if (imem_addr !== 32'h00400200) begin errors++; $display("FAIL nogrant_addr[%0d] got %h exp 00400200", i, imem_addr); end
      checks++; if (Next_PC !== 32'h00400200) begin errors++; $display("FAIL nogrant_next_pc[%0d] got %h exp 00400200", i, Next_PC); end
      cyc();
    end
    imem_gnt = 1;
    cyc();
    imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'h00000033; #1;
    checks++; if (Next_PC !== 32'h00400204) begin errors++; $display("FAIL late_next_pc got %h exp 00400204", Next_PC); end
    cyc();
    imem_rvalid = 0;
    checks++; if (ifid_instr !== 32'h00000033) begin errors++; $display("FAIL late_instr got %h exp 00000033", ifid_instr); end
    checks++; if (ifid_pc !== 32'h00400200) begin errors++; $display("FAIL late_pc got %h exp 00400200", ifid_pc); end
  endtask

  task automatic test_wrap();
    PC_Value = 32'hFFFFFFFC; imem_gnt = 1;
    cyc();
    imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'h0000006F; #1;
    checks++; if (Next_PC !== 32'h00000000) begin errors++; $display("FAIL wrap_next_pc got %h exp 00000000", Next_PC); end
    cyc();
    imem_rvalid = 0; PC_Value = 32'h00400010; id_stall = 1;
    checks++; if (ifid_pc !== 32'hFFFFFFFC) begin errors++; $display("FAIL wrap_pc got %h exp fffffffc", ifid_pc); end
    checks++; if (ifid_pc_plus4 !== 32'h00000000) begin errors++; $display("FAIL wrap_pc4 got %h exp 00000000", ifid_pc_plus4); end
  endtask

  task automatic test_reset_midflight();
    imem_gnt = 1;
    cyc();
    imem_gnt = 0;
    checks++; if (ifid_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_valid got %b exp 1", ifid_valid); end
    #2 reset = 1'b0;
    #1;
    checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_valid got %b exp 0", ifid_valid); end
    checks++; if (ifid_instr !== 32'h00000013) begin errors++; $display("FAIL mid_reset_instr got %h exp 00000013", ifid_instr); end
    checks++; if (ifid_pc !== 32'h0) begin errors++; $display("FAIL mid_reset_pc got %h exp 0", ifid_pc); end
    checks++; if (ifid_pc_plus4 !== 32'h0) begin errors++; $display("FAIL mid_reset_pc4 got %h exp 0", ifid_pc_plus4); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL mid_reset_req got %b exp 0", imem_req); end
    checks++; if (Next_PC !== 32'h00400010) begin errors++; $display("FAIL mid_reset_next_pc got %h exp 00400010", Next_PC); end
    reset = 1'b1; id_stall = 0; imem_rvalid = 1; imem_rdata = 32'hCAFEF00D;
    cyc();
    imem_rvalid = 0;
    checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL stray_valid got %b exp 0", ifid_valid); end
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL post_reset_req got %b exp 1", imem_req); end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_stall();
    test_redirect_wait();
    test_redirect_rvalid();
    test_gnt_delay();
    test_wrap();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
